// File: rtl/svm_byte_packer_if.sv
// svm_byte_packer_if: byte-stream input and 128-bit FIFO write port of the packer.
//   in_data/in_valid/in_last/in_ready : upstream byte handshake
//   wrdata/wrreq/wrfull               : FIFO write side
// slave modport is the packer; master modport is the upstream source / FIFO environment.
interface svm_byte_packer_if;
    localparam int unsigned ByteW = 8;
    localparam int unsigned WordW = 128;

    logic [ByteW-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [WordW-1:0] wrdata;
    logic             wrreq;
    logic             wrfull;

    modport slave (
        input  in_data, in_valid, in_last, wrfull,
        output in_ready, wrdata, wrreq
    );

    modport master (
        output in_data, in_valid, in_last, wrfull,
        input  in_ready, wrdata, wrreq
    );
endinterface

// File: rtl/svm_byte_packer.sv
// svm_byte_packer: packs 16 accepted feature bytes into one 128-bit FIFO word
// (first byte in [7:0]), tracks FrameBytes-long frames, zero-pads a short final
// word and flags frames of the wrong length.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   bus (slave) : byte handshake in, FIFO write out (see svm_byte_packer_if)
//   frame_done  : one-cycle pulse after a frame's last word is written
//   frame_err   : sticky, a frame closed by in_last had the wrong length
//   byte_count  : bytes accepted in the current frame
//   frame_sum   : sum of a frame's bytes, only with SVM_PACKER_CHECKSUM_EN defined
module svm_byte_packer #(
    parameter int unsigned FrameBytes = 512
) (
    input  logic                clk,
    input  logic                reset,
    svm_byte_packer_if.slave    bus,
    output logic                frame_done,
    output logic                frame_err,
    output logic [15:0]         byte_count
`ifdef SVM_PACKER_CHECKSUM_EN
    ,
    output logic [19:0]         frame_sum
`endif
);
    localparam int unsigned WordBytes = 16;
    localparam int unsigned WordW     = WordBytes * 8;
    localparam int unsigned LaneW     = $clog2(WordBytes);
    localparam int unsigned CountW    = 16;
`ifdef SVM_PACKER_CHECKSUM_EN
    localparam int unsigned SumW      = 20;
`endif

    typedef enum logic {
        S_FILL = 1'b0,
        S_PUSH = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WordW-1:0]    r_buf;
    logic [LaneW-1:0]    r_lane;
    logic [CountW-1:0]   r_count;
    logic                r_close;
    logic                r_done;
    logic                r_err;
`ifdef SVM_PACKER_CHECKSUM_EN
    logic [SumW-1:0]     r_acc;
    logic [SumW-1:0]     r_sum;
`endif

    logic                w_in_ready;
    logic                w_wrreq;
    logic                w_accept;
    logic [CountW-1:0]   w_count_inc;
    logic                w_hit_frame;
    logic                w_word_end;
    logic [6:0]          w_bit_idx;

    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_count_inc = r_count + CountW'(1);
    assign w_hit_frame = (w_count_inc == CountW'(FrameBytes));
    assign w_word_end  = (r_lane == LaneW'(WordBytes - 1)) || bus.in_last || w_hit_frame;
    assign w_bit_idx   = {r_lane, 3'b000};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FILL;
        else       r_state <= w_state_nxt;
    end

    // Next-state: a closing byte moves to PUSH, the FIFO write returns to FILL
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL:  if (w_accept && w_word_end) w_state_nxt = S_PUSH;
            S_PUSH:  if (w_wrreq)                w_state_nxt = S_FILL;
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Handshake outputs decoded straight from state so a stalled FIFO never writes
    always_comb begin
        w_in_ready = 1'b0;
        w_wrreq    = 1'b0;
        case (r_state)
            S_FILL:  w_in_ready = 1'b1;
            S_PUSH:  w_wrreq    = !bus.wrfull;
            default: w_in_ready = 1'b0;
        endcase
    end

    // Lane buffer, frame counter and status; the buffer is cleared on each write,
    // so lanes left unfilled by an early in_last read back as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf   <= '0;
            r_lane  <= '0;
            r_count <= '0;
            r_close <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef SVM_PACKER_CHECKSUM_EN
            r_acc   <= '0;
            r_sum   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_buf[w_bit_idx +: 8] <= bus.in_data;
                r_lane                <= r_lane + LaneW'(1);
                r_count               <= w_count_inc;
                r_close               <= bus.in_last || w_hit_frame;
                if (bus.in_last && !w_hit_frame) r_err <= 1'b1;
`ifdef SVM_PACKER_CHECKSUM_EN
                r_acc                 <= r_acc + SumW'(bus.in_data);
`endif
            end else if (w_wrreq) begin
                r_buf  <= '0;
                r_lane <= '0;
                if (r_close) begin
                    r_done  <= 1'b1;
                    r_count <= '0;
                    r_close <= 1'b0;
`ifdef SVM_PACKER_CHECKSUM_EN
                    r_sum   <= r_acc;
                    r_acc   <= '0;
`endif
                end
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.wrreq    = w_wrreq;
    assign bus.wrdata   = r_buf;
    assign frame_done   = r_done;
    assign frame_err    = r_err;
    assign byte_count   = r_count;
`ifdef SVM_PACKER_CHECKSUM_EN
    assign frame_sum    = r_sum;
`endif

endmodule
